// File: rtl/syndrome_gen.sv
// BCH odd-syndrome generator: Horner-accumulates S1/S3/S5/S7 over GF(2^m), one hard bit per cycle,
// highest-degree bit first, and presents the result with a one-cycle valid.
module syndrome_gen (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [1:0] i_code,
  input  logic       i_bit,
  input  logic       i_bit_valid,
  output logic       o_busy,
  output logic [9:0] o_S1,
  output logic [9:0] o_S3,
  output logic [9:0] o_S5,
  output logic [9:0] o_S7,
  output logic       o_valid,
  output logic [1:0] o_code
);

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  state_e     state_q, state_d;
  logic [1:0] code_q, code_d;
  logic [9:0] cnt_q, cnt_d;
  logic [9:0] s1_q, s1_d, s3_q, s3_d, s5_q, s5_d, s7_q, s7_d;
  logic [9:0] last_idx;
  logic       wide;

  // One multiply-by-alpha step; the result never carries bits at or above m.
  function automatic logic [9:0] mul_alpha(input logic [9:0] v, input logic [1:0] code);
    logic [9:0] r;
    r = '0;
    case (code)
      2'b01:   r = {2'b00, v[6:0], 1'b0} ^ (v[7] ? 10'h01D : 10'h000);
      2'b10:   r = {v[8:0], 1'b0} ^ (v[9] ? 10'h009 : 10'h000);
      default: r = {4'b0000, v[4:0], 1'b0} ^ (v[5] ? 10'h003 : 10'h000);
    endcase
    return r;
  endfunction

  function automatic logic [9:0] mul_pow(input logic [9:0] v, input logic [1:0] code,
                                         input int unsigned j);
    logic [9:0] r;
    r = v;
    for (int unsigned i = 0; i < j; i++) begin
      r = mul_alpha(r, code);
    end
    return r;
  endfunction

  always_comb begin
    case (code_q)
      2'b01:   last_idx = 10'd254;
      2'b10:   last_idx = 10'd1022;
      default: last_idx = 10'd62;
    endcase
  end

  assign wide = (code_q == 2'b10);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s3_d    = s3_q;
    s5_d    = s5_q;
    s7_d    = s7_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StAcc;
          code_d  = i_code;
          cnt_d   = '0;
          s1_d    = '0;
          s3_d    = '0;
          s5_d    = '0;
          s7_d    = '0;
        end
      end
      StAcc: begin
        if (i_bit_valid) begin
          cnt_d = cnt_q + 10'd1;
          s1_d  = mul_pow(s1_q, code_q, 1) ^ {9'd0, i_bit};
          s3_d  = mul_pow(s3_q, code_q, 3) ^ {9'd0, i_bit};
          // S5/S7 only carry meaning for the long code.
          s5_d  = wide ? (mul_pow(s5_q, code_q, 5) ^ {9'd0, i_bit}) : 10'd0;
          s7_d  = wide ? (mul_pow(s7_q, code_q, 7) ^ {9'd0, i_bit}) : 10'd0;
          if (cnt_q == last_idx) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      code_q  <= 2'b00;
      cnt_q   <= '0;
      s1_q    <= '0;
      s3_q    <= '0;
      s5_q    <= '0;
      s7_q    <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s3_q    <= s3_d;
      s5_q    <= s5_d;
      s7_q    <= s7_d;
    end
  end

  assign o_busy  = (state_q == StAcc);
  assign o_valid = (state_q == StDone);
  assign o_code  = code_q;
  assign o_S1    = s1_q;
  assign o_S3    = s3_q;
  assign o_S5    = s5_q;
  assign o_S7    = s7_q;

endmodule

// File: tb/tb_syndrome_gen.sv
// Self-checking bench for syndrome_gen: hand-computed single-error vectors plus random words
// checked against a power-sum model, with gaps, stray starts and a mid-word reset.
module tb_syndrome_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] code;
  logic       bit_in;
  logic       bit_valid;
  logic       busy;
  logic [9:0] s1, s3, s5, s7;
  logic       valid;
  logic [1:0] code_out;

  int n_cmp = 0;
  int n_err = 0;

  logic data_bits [0:1023];

  typedef struct {
    logic [1:0] code;
    int         pos;
    logic [9:0] e1, e3, e5, e7;
  } vec_t;

  vec_t vecs [8];

  syndrome_gen dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_code      (code),
    .i_bit       (bit_in),
    .i_bit_valid (bit_valid),
    .o_busy      (busy),
    .o_S1        (s1),
    .o_S3        (s3),
    .o_S5        (s5),
    .o_S7        (s7),
    .o_valid     (valid),
    .o_code      (code_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic int nbits(input logic [1:0] c);
    case (c)
      2'b01:   return 255;
      2'b10:   return 1023;
      default: return 63;
    endcase
  endfunction

  // Multiply by x with reduction by the full primitive polynomial.
  function automatic logic [9:0] xtimes(input logic [9:0] v, input logic [1:0] c);
    logic [10:0] t;
    t = {v, 1'b0};
    case (c)
      2'b01:   if (t[8])  t = t ^ 11'h11D;
      2'b10:   if (t[10]) t = t ^ 11'h409;
      default: if (t[6])  t = t ^ 11'h043;
    endcase
    return t[9:0];
  endfunction

  // S_j = sum r_k alpha^(jk), built up by ascending powers.
  task automatic model(input logic [1:0] c, output logic [9:0] e1, e3, e5, e7);
    logic [9:0] pw [4];
    logic [9:0] acc [4];
    for (int j = 0; j < 4; j++) begin
      pw[j]  = 10'd1;
      acc[j] = 10'd0;
    end
    for (int k = 0; k < nbits(c); k++) begin
      for (int j = 0; j < 4; j++) begin
        if (data_bits[k]) acc[j] = acc[j] ^ pw[j];
        for (int r = 0; r < 2 * j + 1; r++) pw[j] = xtimes(pw[j], c);
      end
    end
    e1 = acc[0];
    e3 = acc[1];
    e5 = (c == 2'b10) ? acc[2] : 10'd0;
    e7 = (c == 2'b10) ? acc[3] : 10'd0;
  endtask

  task automatic send_word(input logic [1:0] c, input bit gaps, input bit mid_start,
                           input bit start_in_done, input string name,
                           output logic [9:0] r1, r3, r5, r7, output logic [1:0] rc);
    bit early;
    int n;
    early = 1'b0;
    n     = nbits(c);
    start = 1'b1;
    code  = c;
    tick();
    start = 1'b0;
    check({name, " busy after start"}, {9'd0, busy}, 10'd1);
    for (int k = n - 1; k >= 0; k--) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          if (valid) early = 1'b1;
          bit_in    = 1'($urandom);
          bit_valid = 1'b0;
          tick();
        end
      end
      if (mid_start && k == n / 2) begin
        start     = 1'b1;
        code      = 2'b10;
        bit_valid = 1'b0;
        tick();
        start = 1'b0;
      end
      if (valid) early = 1'b1;
      bit_in    = data_bits[k];
      bit_valid = 1'b1;
      tick();
      bit_valid = 1'b0;
    end
    check({name, " valid before last bit"}, {9'd0, early}, 10'd0);
    check({name, " valid after last bit"}, {9'd0, valid}, 10'd1);
    check({name, " busy in valid cycle"}, {9'd0, busy}, 10'd0);
    r1 = s1;
    r3 = s3;
    r5 = s5;
    r7 = s7;
    rc = code_out;
    if (start_in_done) begin
      start = 1'b1;
      code  = 2'b10;
    end
    bit_valid = 1'b1;
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
    check({name, " valid one cycle"}, {9'd0, valid}, 10'd0);
    check({name, " busy after done"}, {9'd0, busy}, 10'd0);
  endtask

  task automatic check_syn(input string name, input logic [1:0] c, input logic [9:0] r1, r3, r5,
                           r7, input logic [1:0] rc, input logic [9:0] e1, e3, e5, e7);
    check({name, " S1"}, r1, e1);
    check({name, " S3"}, r3, e3);
    check({name, " S5"}, r5, e5);
    check({name, " S7"}, r7, e7);
    check({name, " code"}, {8'd0, rc}, {8'd0, c});
    check({name, " S1 hold"}, s1, e1);
    check({name, " S3 hold"}, s3, e3);
  endtask

  initial begin
    logic [9:0] r1, r3, r5, r7, e1, e3, e5, e7;
    logic [1:0] rc;
    bit         seen;

    vecs[0] = '{code: 2'b00, pos: -1, e1: 10'h000, e3: 10'h000, e5: 10'h000, e7: 10'h000};
    vecs[1] = '{code: 2'b10, pos: 0,  e1: 10'h001, e3: 10'h001, e5: 10'h001, e7: 10'h001};
    vecs[2] = '{code: 2'b10, pos: 1,  e1: 10'h002, e3: 10'h008, e5: 10'h020, e7: 10'h080};
    vecs[3] = '{code: 2'b00, pos: 62, e1: 10'h021, e3: 10'h039, e5: 10'h000, e7: 10'h000};
    vecs[4] = '{code: 2'b01, pos: 0,  e1: 10'h001, e3: 10'h001, e5: 10'h000, e7: 10'h000};
    vecs[5] = '{code: 2'b01, pos: 1,  e1: 10'h002, e3: 10'h008, e5: 10'h000, e7: 10'h000};
    vecs[6] = '{code: 2'b10, pos: 2,  e1: 10'h004, e3: 10'h040, e5: 10'h009, e7: 10'h090};
    vecs[7] = '{code: 2'b11, pos: 1,  e1: 10'h002, e3: 10'h008, e5: 10'h000, e7: 10'h000};

    rst       = 1'b1;
    start     = 1'b0;
    code      = 2'b11;
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    tick();
    tick();
    check("reset busy", {9'd0, busy}, 10'd0);
    check("reset valid", {9'd0, valid}, 10'd0);
    check("reset S1", s1, 10'd0);
    check("reset S7", s7, 10'd0);
    check("reset code", {8'd0, code_out}, 10'd0);
    rst       = 1'b0;
    bit_valid = 1'b0;
    tick();

    for (int v = 0; v < 8; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      for (int k = 0; k < 1024; k++) data_bits[k] = (k == vecs[v].pos);
      send_word(vecs[v].code, 1'b0, 1'b0, 1'b0, nm, r1, r3, r5, r7, rc);
      check_syn(nm, vecs[v].code, r1, r3, r5, r7, rc,
                vecs[v].e1, vecs[v].e3, vecs[v].e5, vecs[v].e7);
    end

    // Code 01 random word with bubbles, a stray start mid-word and a start during valid.
    for (int k = 0; k < 1024; k++) data_bits[k] = 1'($urandom);
    model(2'b01, e1, e3, e5, e7);
    send_word(2'b01, 1'b1, 1'b1, 1'b1, "rand01", r1, r3, r5, r7, rc);
    check_syn("rand01", 2'b01, r1, r3, r5, r7, rc, e1, e3, e5, e7);

    for (int k = 0; k < 1024; k++) data_bits[k] = 1'($urandom);
    model(2'b10, e1, e3, e5, e7);
    send_word(2'b10, 1'b0, 1'b0, 1'b0, "rand10", r1, r3, r5, r7, rc);
    check_syn("rand10", 2'b10, r1, r3, r5, r7, rc, e1, e3, e5, e7);

    for (int k = 0; k < 1024; k++) data_bits[k] = 1'($urandom);
    model(2'b00, e1, e3, e5, e7);
    send_word(2'b00, 1'b1, 1'b0, 1'b0, "rand00", r1, r3, r5, r7, rc);
    check_syn("rand00", 2'b00, r1, r3, r5, r7, rc, e1, e3, e5, e7);

    // Reset after 100 bits of a code-10 word.
    start = 1'b1;
    code  = 2'b10;
    tick();
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      bit_in    = (k % 3 == 0);
      bit_valid = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", {9'd0, busy}, 10'd0);
    check("abort S1", s1, 10'd0);
    check("abort S3", s3, 10'd0);
    check("abort S5", s5, 10'd0);
    check("abort code", {8'd0, code_out}, 10'd0);
    seen = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      bit_in    = 1'($urandom);
      bit_valid = 1'b1;
      if (valid) seen = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    check("abort no valid", {9'd0, seen}, 10'd0);
    for (int k = 0; k < 1024; k++) data_bits[k] = 1'b0;
    send_word(2'b10, 1'b0, 1'b0, 1'b0, "fresh", r1, r3, r5, r7, rc);
    check_syn("fresh", 2'b10, r1, r3, r5, r7, rc, 10'd0, 10'd0, 10'd0, 10'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
